// File: rtl/fwd_scoreboard.sv
// Hazard and forwarding controller: a shift-register scoreboard of in-flight
// register writers that drives per-port forward selects and a global D-stage stall.
module fwd_scoreboard #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int NREAD = 4,
    parameter int TW    = 2,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_waddr,
    input  logic [TW-1:0]       issue_tnew,
    input  logic [NREAD*AW-1:0] raddr,
    input  logic [NREAD*SW-1:0] rstage,
    input  logic [NREAD*TW-1:0] rtuse,
    input  logic [NREAD*DW-1:0] rdata_rf,
    input  logic [DEPTH*DW-1:0] stage_data,
    output logic [NREAD*SW-1:0] fwd_sel,
    output logic [NREAD*DW-1:0] fwd_data,
    output logic                stall
);

    logic [DEPTH:1] v_q, v_d;
    logic [AW-1:0]  waddr_q [1:DEPTH];
    logic [AW-1:0]  waddr_d [1:DEPTH];
    logic [TW-1:0]  tnew_q  [1:DEPTH];
    logic [TW-1:0]  tnew_d  [1:DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                waddr_q[k] <= '0;
                tnew_q[k]  <= '0;
            end
        end else begin
            v_q     <= v_d;
            waddr_q <= waddr_d;
            tnew_q  <= tnew_d;
        end
    end

    // Stage 1 takes the D instruction unless stalled; older stages age by one.
    always_comb begin
        v_d = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            waddr_d[k] = '0;
            tnew_d[k]  = '0;
        end
        v_d[1] = !stall && issue_valid && (issue_waddr != '0);
        if (!stall) begin
            waddr_d[1] = issue_waddr;
            tnew_d[1]  = issue_tnew;
        end
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            v_d[k]     = v_q[k-1];
            waddr_d[k] = waddr_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
        end
    end

    logic          found;
    int unsigned   win_k;
    logic [TW-1:0] win_tnew;
    logic [AW-1:0] ra;
    int unsigned   rs;

    always_comb begin
        stall    = 1'b0;
        fwd_sel  = '0;
        fwd_data = '0;
        found    = 1'b0;
        win_k    = 0;
        win_tnew = '0;
        ra       = '0;
        rs       = 0;
        for (int unsigned p = 0; p < NREAD; p++) begin
            ra       = raddr[p*AW +: AW];
            rs       = 32'(rstage[p*SW +: SW]);
            found    = 1'b0;
            win_k    = 0;
            win_tnew = '0;
            // Scan from youngest stage; first match shadows older writers.
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (!found && v_q[k] && (waddr_q[k] == ra) && (ra != '0) && (k > rs)) begin
                    found    = 1'b1;
                    win_k    = k;
                    win_tnew = tnew_q[k];
                end
            end
            if (found && (win_tnew == '0)) begin
                fwd_sel[p*SW +: SW]  = SW'(win_k);
                fwd_data[p*DW +: DW] = stage_data[(win_k - 1) * DW +: DW];
            end else begin
                fwd_data[p*DW +: DW] = rdata_rf[p*DW +: DW];
            end
            if (found && (rs == 0) && (win_tnew > rtuse[p*TW +: TW]))
                stall = 1'b1;
        end
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised hazard and forwarding controller for the pipelined MIPS core. It replaces the hand-wired per-stage forwarding muxes and their external select logic with one block. The block keeps a small shift-register scoreboard of in-flight register writers (destination, "cycles until result", valid) for every pipeline register after D. From that scoreboard it computes, per read port, the forwarded operand value, its source select, and a global D-stage stall.

## Interface
Parameters:
- DW, 32, data width.
- AW, 5, register address width; address 0 is hard-wired zero.
- DEPTH, 3, stored stages after D (1=E, 2=M, 3=W).
- NREAD, 4, number of read ports (e.g. rs_D, rt_D, rs_E, rt_E).
- TW, 2, width of Tnew/Tuse counters.
- SW, $clog2(DEPTH+1), width of one forward select.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears scoreboard.
- issue_valid  in  1  instruction in D writes a register.
- issue_waddr  in  AW  its destination register.
- issue_tnew  in  TW  Tnew it will hold on entering stage 1 (ALU/jal=1, load=2).
- raddr  in  NREAD*AW  source register per port.
- rstage  in  NREAD*SW  stage the consumer sits in (0=D, 1=E, …).
- rtuse  in  NREAD*TW  cycles until consumer needs the value (used only when rstage=0).
- rdata_rf  in  NREAD*DW  register-file or pipeline-register value per port.
- stage_data  in  DEPTH*DW  writer value held in pipeline register of stage k (k=1..DEPTH).
- fwd_sel  out  NREAD*SW  0 = rdata_rf, k = stage_data[k].
- fwd_data  out  NREAD*DW  selected operand.
- stall  out  1  freeze F/D, bubble into stage 1.

## Operation
- Scoreboard entry per stage k (1..DEPTH): {v, waddr, tnew}. Reset value: v=0, waddr=0, tnew=0.
- Rising edge, stall=0: entry[1] <= {issue_valid && issue_waddr!=0, issue_waddr, issue_tnew}.
- Rising edge, stall=1: entry[1] <= bubble (v=0). The issue inputs are ignored that cycle and D re-presents them.
- Rising edge, always: entry[k] <= entry[k-1] for k≥2, with tnew decremented, saturating at 0. The last stage's entry is discarded.
- Match for port p, stage k: entry[k].v && entry[k].waddr==raddr[p] && raddr[p]!=0 && k>rstage[p].
- Selection: the youngest match (smallest k) wins. Older stages holding the same register are ignored.
- If the winner has tnew==0: fwd_sel[p]=k and fwd_data[p]=stage_data[k].
- If the winner has tnew>0, or there is no match: fwd_sel[p]=0 and fwd_data[p]=rdata_rf[p]. The value is forwarded later in a downstream stage.
- Stall: OR over ports with rstage==0 of (winner exists && winner.tnew > rtuse[p]).
- Ports with rstage≥1 never contribute to stall.
- raddr==0 never matches: fwd_sel=0 and no stall.
- All outputs are combinational from current scoreboard state and inputs. There is no internal register on outputs.

## Timing
- Reset: asynchronous assertion clears all entries immediately.
- Outputs during reset: stall=0, and fwd_sel=0 for every port. fwd_data follows rdata_rf.
- Reset release takes effect at the next rising edge.
- A writer issued in cycle n is visible in stage 1 from cycle n+1 and in stage k from cycle n+k.
- Stall latency: stall rises in the same cycle the hazardous consumer appears in D (zero cycle).
- Stall lasts exactly max(winner.tnew − rtuse) cycles, because tnew falls by 1 per edge.
- Load-use case (tnew=2, tuse=1): exactly 1 stall cycle.
- Simultaneous issue and stall: issue is dropped and the bubble is inserted. The issuing instruction is not lost, since D holds it.
- Writer leaving stage DEPTH: after that edge no match exists, so the port reads rdata_rf. The register file must be write-before-read.
- Reset mid-stall: stall deasserts asynchronously and every in-flight entry is lost.

## Test plan
- Reset: assert reset with random inputs. Required: stall=0, all fwd_sel=0, fwd_data==rdata_rf. Release, then issue nothing for 4 cycles; outputs stay unchanged.
- ALU→branch: issue $5 with tnew=1. Next cycle, port0 raddr=5, rstage=0, rtuse=0. Required: stall=1 for exactly 1 cycle. The following cycle stall=0, fwd_sel[0]=2, fwd_data[0]=stage_data[2] (e.g. 0x0000_1234).
- Load-use: issue $8 with tnew=2. Consumer in D with rtuse=1: stall=1 for 1 cycle, then 0 with fwd_sel=0. Next cycle, a port with rstage=1 on $8 gives fwd_sel=3 and data from stage_data[3].
- Youngest wins: $3 written at M (tnew 0) and at W (tnew 0). Port with rstage=0, raddr=3 gives fwd_sel=2 and stage_data[2], not stage 3.
- $0: issue writer to $0, then a consumer with raddr=0, rtuse=0. Required: stall=0, fwd_sel=0, and entry[1].v==0.
- Reset mid-stall: create the load-use stall, then assert reset in the middle of the stall cycle. Required: stall drops before the next edge. After release, the $8 consumer sees fwd_sel=0 and no stall.
